// File: rtl/aes_pkg.sv
// Shared AES ShiftRows helpers: row offsets, byte positions, legal state widths.
package aes_pkg;

  // Offset applied to row r for a state of nb columns (Rijndael: 8 columns shift rows 2/3 by 3/4).
  function automatic int shift_off(input int nb, input int r);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction

  // MSB bit index of byte s[r][c] in a column-major vector with byte 0 at the top.
  function automatic int byte_pos(input int r, input int c, input int nb);
    return 32 * nb - 1 - 8 * (4 * c + r);
  endfunction

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

endpackage

// File: rtl/shiftrow_perm.sv
// Combinational ShiftRows byte permutation, forward or inverse (inverse built only with SHIFTROW_INV_EN).
// Zero latency, no state, no handshake.
module shiftrow_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] data,
  input  logic             inv,
  output logic [32*NB-1:0] perm
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int FWD = (c + shift_off(NB, r)) % NB;
`ifdef SHIFTROW_INV_EN
      localparam int INV = (c + NB - shift_off(NB, r)) % NB;
      assign perm[byte_pos(r, c, NB) -: 8] = inv ? data[byte_pos(r, INV, NB) -: 8]
                                                 : data[byte_pos(r, FWD, NB) -: 8];
`else
      assign perm[byte_pos(r, c, NB) -: 8] = data[byte_pos(r, FWD, NB) -: 8];
`endif
    end
  end

`ifndef SHIFTROW_INV_EN
  logic unused_inv;
  assign unused_inv = inv;
`endif

endmodule

// File: rtl/shiftrow_pipe.sv
// Registered ShiftRows stage with 2-entry output buffer; 1-cycle latency when empty (SHIFTROW_INV_EN enables inverse).
// Backpressure: in_ready = not full, from registered count only; blocks are never dropped.
module shiftrow_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32*NB-1:0] in_data,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shiftrow_pipe: NB must be 4, 6 or 8");
  end

  logic [32*NB-1:0] perm_data;
  logic [32*NB-1:0] mem_data [2];
  logic [TAG_W-1:0] mem_tag  [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  shiftrow_perm #(.NB(NB)) u_perm (
    .data (in_data),
    .inv  (in_inv),
    .perm (perm_data)
  );

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem_data[rd_ptr];
  assign out_tag   = mem_tag[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_tag[i]  <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= perm_data;
        mem_tag[wr_ptr]  <= in_tag;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftrow_pipe.sv
// Directed + randomized bench for shiftrow_pipe against a byte-level ShiftRows model and a queue scoreboard.
module tb_shiftrow_pipe;

`ifdef SHIFTROW_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_inv, out_ready;
  logic         in_ready, out_valid;
  logic [127:0] in_data, out_data;
  logic [3:0]   in_tag, out_tag;

  logic         in_valid8, in_inv8, out_ready8;
  logic         in_ready8, out_valid8;
  logic [255:0] in_data8, out_data8;
  logic [3:0]   in_tag8, out_tag8;

  always #5 clk = ~clk;

  shiftrow_pipe #(.NB(4), .TAG_W(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  shiftrow_pipe #(.NB(8), .TAG_W(4)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_inv(in_inv8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_tag(out_tag8)
  );

  typedef struct {
    logic [127:0] d;
    logic [3:0]   t;
  } ent_t;

  ent_t q[$];
  bit   fresh;
  int   checks = 0;
  int   errors = 0;

  // Reference ShiftRows: out[r][c] = in[r][(c +/- off[r]) mod nb], byte k of column c at index 4c+r.
  function automatic logic [255:0] ref_perm(input logic [255:0] d, input int nb, input bit inv);
    logic [255:0] o;
    int off, src;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      off = (nb == 8 && r > 1) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - off + nb) % nb : (c + off) % nb;
        o[32*nb-1-8*(4*c+r) -: 8] = d[32*nb-1-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Compare outputs with the model, apply this cycle's handshake to the model, advance one clock.
  task automatic step(output bit accepted);
    logic [255:0] p;
    bit pop;
    check("in_ready", {255'd0, in_ready}, {255'd0, q.size() != 2});
    check("out_valid", {255'd0, out_valid}, {255'd0, q.size() != 0});
    if (q.size() != 0) begin
      check("out_data", {128'd0, out_data}, {128'd0, q[0].d});
      check("out_tag", {252'd0, out_tag}, {252'd0, q[0].t});
    end else if (fresh) begin
      check("cleared_data", {128'd0, out_data}, 256'd0);
      check("cleared_tag", {252'd0, out_tag}, 256'd0);
    end
    accepted = !rst && in_valid && (q.size() != 2);
    pop      = !rst && out_ready && (q.size() != 0);
    if (rst) begin
      q.delete();
      fresh = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (accepted) begin
        p = ref_perm({128'd0, in_data}, 4, in_inv && INV_EN);
        q.push_back('{d: p[127:0], t: in_tag});
        fresh = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_block();
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_tag  = 4'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n, cyc;
    logic [255:0] exp8, v8;

    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_inv8 = 1'b0; in_data8 = '0; in_tag8 = '0; out_ready8 = 1'b1;
    fresh = 1'b1;
    @(negedge clk);
    step(acc);
    rst = 1'b0;

    // Reset state of both instances
    check("rst_in_ready8", {255'd0, in_ready8}, 256'd1);
    check("rst_out_valid8", {255'd0, out_valid8}, 256'd0);
    check("rst_out_data8", out_data8, 256'd0);

    // NB=4 forward directed vector
    in_valid = 1'b1; in_inv = 1'b0; out_ready = 1'b1; in_tag = 4'd5;
    in_data = 128'h000102030405060708090a0b0c0d0e0f;
    step(acc);
    in_valid = 1'b0;
    check("fwd4_data", {128'd0, out_data}, {128'd0, 128'h00050a0f04090e03080d02070c01060b});
    check("fwd4_tag", {252'd0, out_tag}, 256'd5);
    step(acc);

    // NB=4 inverse directed vector (forward result when the inverse is not built)
    in_valid = 1'b1; in_inv = 1'b1; in_tag = 4'd9;
    step(acc);
    in_valid = 1'b0;
    if (INV_EN) check("inv4_data", {128'd0, out_data}, {128'd0, 128'h000d0a0704010e0b0805020f0c090603});
    else        check("inv4_data", {128'd0, out_data}, {128'd0, 128'h00050a0f04090e03080d02070c01060b});
    step(acc);

    // NB=8 forward, byte i = i
    for (int i = 0; i < 32; i++) in_data8[255-8*i -: 8] = 8'(i);
    in_valid8 = 1'b1; in_tag8 = 4'd3;
    @(negedge clk);
    in_valid8 = 1'b0;
    exp8 = ref_perm(in_data8, 8, 1'b0);
    v8 = out_data8;
    check("fwd8_valid", {255'd0, out_valid8}, 256'd1);
    check("fwd8_col0", {224'd0, v8[255:224]}, {224'd0, 32'h00050e13});
    check("fwd8_col7", {224'd0, v8[31:0]}, {224'd0, exp8[31:0]});
    check("fwd8_data", out_data8, exp8);
    check("fwd8_tag", {252'd0, out_tag8}, 256'd3);

    // Back-pressure: three blocks offered into a stalled sink, source holds the third
    out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0;
    rand_block();
    n = 0; cyc = 0;
    while (n < 3 && cyc < 12) begin
      if (cyc == 4) out_ready = 1'b1;
      step(acc);
      cyc++;
      if (acc) begin
        n++;
        rand_block();
      end
    end
    check("bp_accepted", 256'(n), 256'd3);
    check("bp_cycles", 256'(cyc), 256'd6);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step(acc);

    // Streaming with alternating in_inv: one block in, one out, every cycle
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_block();
      in_inv = i[0];
      step(acc);
      check("stream_accept", {255'd0, acc}, 256'd1);
      if (i > 0) check("stream_count1", 256'(q.size()), 256'd1);
    end
    in_valid = 1'b0;
    step(acc);

    // Random traffic, data scrambled while idle
    for (int i = 0; i < 300; i++) begin
      rand_block();
      in_valid  = 1'($urandom_range(0, 1));
      in_inv    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step(acc);
    end

    // Reset with two entries buffered
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_block();
      step(acc);
    end
    check("prerst_full", 256'(q.size()), 256'd2);
    rst = 1'b1;
    step(acc);
    rst = 1'b0; in_valid = 1'b0;
    check("postrst_valid", {255'd0, out_valid}, 256'd0);
    check("postrst_ready", {255'd0, in_ready}, 256'd1);
    check("postrst_data", {128'd0, out_data}, 256'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
